// File: rtl/dic_cmd_fsm.sv
`default_nettype none
// ============================================================================
// Module      : dic_cmd_fsm
// Description : Control-path FSM for the digital clock. Decodes UART command
//               tokens (S, CR, L, A, @, ESC, digits) into run/stop control,
//               per-digit load strobes and display enables for the time
//               digits and NALM alarm registers. Supports ESC abort, an
//               inactivity timeout during entry, an entry-error pulse and
//               per-channel alarm enables.
// Ports       : clk_i, rst_ni         clock, asynchronous active-low reset
//               det_*_i               1-cycle token pulses from the decoder
//               num_val_i             binary digit value, valid with det_num_i
//               dic_run_o             clock counting enabled
//               ld_time_o/ld_alm_o    one-hot digit load strobes (Mealy)
//               dsp_time_o/dsp_alm_o  per-digit display enables
//               alm_sel_o, alm_en_o   selected alarm channel, channel enables
//               entry_err_o           1-cycle rejected-entry / timeout pulse
// Revision    : 1.0 - initial release
// ============================================================================
module dic_cmd_fsm #(
    parameter int NDIG    = 4,
    parameter int NALM    = 2,
    parameter int ASW     = 1,
    parameter int TMO_W   = 24,
    parameter int TMO_CYC = 0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            det_cr_i,
    input  logic            det_S_i,
    input  logic            det_L_i,
    input  logic            det_A_i,
    input  logic            det_atSign_i,
    input  logic            det_esc_i,
    input  logic            det_num_i,
    input  logic            det_num0to5_i,
    input  logic [3:0]      num_val_i,
    output logic            dic_run_o,
    output logic [NDIG-1:0] ld_time_o,
    output logic [NDIG-1:0] dsp_time_o,
    output logic [NDIG-1:0] ld_alm_o,
    output logic [NDIG-1:0] dsp_alm_o,
    output logic [ASW-1:0]  alm_sel_o,
    output logic [NALM-1:0] alm_en_o,
    output logic            entry_err_o
);

    localparam int                    c_ptr_w    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [c_ptr_w-1:0]    c_ptr_top  = c_ptr_w'(NDIG - 1);
    localparam logic [4:0]            c_nalm     = 5'(NALM);
    localparam bit                    c_tmo_en   = (TMO_CYC > 0);
    localparam logic [TMO_W-1:0]      c_tmo_last = TMO_W'((TMO_CYC > 0) ? (TMO_CYC - 1) : 0);

    typedef enum logic [2:0] {
        ST_STOP  = 3'd0,
        ST_RUN   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ASEL  = 3'd3,
        ST_ALOAD = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [c_ptr_w-1:0]  ptr_q, ptr_d;
    logic [ASW-1:0]      alm_sel_q, alm_sel_d;
    logic [NALM-1:0]     alm_en_q, alm_en_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                run_save_q, run_save_d;
    logic                done_alm_q, done_alm_d;   // DONE was reached from ALOAD

    logic                w_in_entry;
    logic                w_dig_ok;
    logic                w_chan_ok;
    logic                w_tmo_hit;
    logic [NDIG-1:0]     w_ld_onehot;
    logic [NDIG-1:0]     w_above;
    state_t              w_exit_st;

    assign w_in_entry  = (state_q == ST_LOAD) || (state_q == ST_ASEL) || (state_q == ST_ALOAD);
    // Odd pointer positions hold tens digits, which only accept 0-5.
    assign w_dig_ok    = ptr_q[0] ? det_num0to5_i : det_num_i;
    assign w_chan_ok   = det_num_i && ({1'b0, num_val_i} < c_nalm);
    assign w_tmo_hit   = c_tmo_en && (tmo_q == c_tmo_last);
    assign w_ld_onehot = NDIG'(1) << ptr_q;
    assign w_exit_st   = run_save_q ? ST_RUN : ST_STOP;

    // Digits above the pointer have already been entered and are shown.
    always_comb begin
        w_above = '0;
        for (int i = 0; i < NDIG; i++) begin
            w_above[i] = (i > 32'(ptr_q));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_STOP;
            ptr_q      <= c_ptr_top;
            alm_sel_q  <= '0;
            alm_en_q   <= '0;
            tmo_q      <= '0;
            run_save_q <= 1'b0;
            done_alm_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            alm_sel_q  <= alm_sel_d;
            alm_en_q   <= alm_en_d;
            tmo_q      <= tmo_d;
            run_save_q <= run_save_d;
            done_alm_q <= done_alm_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        alm_sel_d   = alm_sel_q;
        alm_en_d    = alm_en_q;
        run_save_d  = run_save_q;
        done_alm_d  = done_alm_q;
        // Saturating inactivity counter; only meaningful during entry.
        tmo_d       = (w_in_entry && !(&tmo_q)) ? tmo_q + 1'b1 : tmo_q;
        ld_time_o   = '0;
        ld_alm_o    = '0;
        entry_err_o = 1'b0;

        // Alarm enable toggle works in every state, alongside FSM tokens.
        if (det_atSign_i) begin
            alm_en_d = alm_en_q ^ (NALM'(1) << alm_sel_q);
        end

        case (state_q)
            ST_STOP, ST_RUN: begin
                if (det_cr_i || det_S_i) begin
                    if (state_q == ST_RUN) begin
                        state_d = det_cr_i ? ST_STOP : ST_RUN;
                    end else begin
                        state_d = det_S_i ? ST_RUN : ST_STOP;
                    end
                end else if (det_A_i || det_L_i) begin
                    state_d    = det_A_i ? ST_ASEL : ST_LOAD;
                    run_save_d = (state_q == ST_RUN);
                    ptr_d      = c_ptr_top;
                    tmo_d      = '0;
                end
            end

            ST_ASEL: begin
                if (det_esc_i) begin
                    state_d = w_exit_st;
                end else if (w_chan_ok) begin
                    alm_sel_d = num_val_i[ASW-1:0];
                    state_d   = ST_ALOAD;
                    tmo_d     = '0;
                end else begin
                    if (det_num_i) begin
                        entry_err_o = 1'b1;
                    end
                    if (w_tmo_hit) begin
                        entry_err_o = 1'b1;
                        state_d     = w_exit_st;
                    end
                end
            end

            ST_LOAD, ST_ALOAD: begin
                if (det_esc_i) begin
                    state_d = w_exit_st;
                end else if (det_num_i && w_dig_ok) begin
                    if (state_q == ST_LOAD) begin
                        ld_time_o = w_ld_onehot;
                    end else begin
                        ld_alm_o = w_ld_onehot;
                    end
                    tmo_d = '0;
                    if (ptr_q == '0) begin
                        state_d    = ST_DONE;
                        done_alm_d = (state_q == ST_ALOAD);
                    end else begin
                        ptr_d = ptr_q - 1'b1;
                    end
                end else begin
                    if (det_num_i) begin
                        entry_err_o = 1'b1;
                    end
                    if (w_tmo_hit) begin
                        entry_err_o = 1'b1;
                        state_d     = w_exit_st;
                    end
                end
            end

            ST_DONE: begin
                if (det_cr_i) begin
                    state_d = ST_STOP;
                end else if (det_S_i) begin
                    state_d = ST_RUN;
                end else if (det_esc_i) begin
                    state_d = w_exit_st;
                end
            end

            default: begin
                state_d = ST_STOP;
            end
        endcase
    end

    always_comb begin
        dsp_time_o = '0;
        dsp_alm_o  = '0;
        case (state_q)
            ST_STOP, ST_RUN: dsp_time_o = '1;
            ST_LOAD:         dsp_time_o = w_above;
            ST_ALOAD:        dsp_alm_o  = w_above;
            ST_DONE: begin
                if (done_alm_q) begin
                    dsp_alm_o = '1;
                end else begin
                    dsp_time_o = '1;
                end
            end
            default: begin
                dsp_time_o = '0;
                dsp_alm_o  = '0;
            end
        endcase
    end

    assign dic_run_o = (state_q == ST_RUN);
    assign alm_sel_o = alm_sel_q;
    assign alm_en_o  = alm_en_q;

endmodule
`default_nettype wire

// File: tb/tb_dic_cmd_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_dic_cmd_fsm
// Description : Self-checking bench for dic_cmd_fsm (NDIG=4, NALM=2,
//               TMO_CYC=8). Table of per-cycle tokens with expected outputs,
//               followed by directed timeout and mid-entry reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dic_cmd_fsm;

    localparam int T_NONE = 0;
    localparam int T_CR   = 1;
    localparam int T_S    = 2;
    localparam int T_L    = 3;
    localparam int T_A    = 4;
    localparam int T_AT   = 5;
    localparam int T_ESC  = 6;
    localparam int T_NUM  = 7;

    typedef struct {
        int         tok;
        logic [3:0] val;
        logic [20:0] exp;   // {run, ld_time, dsp_time, ld_alm, dsp_alm, sel, en, err}
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic det_cr, det_S, det_L, det_A, det_at, det_esc, det_num, det_num05;
    logic [3:0] num_val;
    logic       dic_run;
    logic [3:0] ld_time, dsp_time, ld_alm, dsp_alm;
    logic [0:0] alm_sel;
    logic [1:0] alm_en;
    logic       entry_err;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    dic_cmd_fsm #(
        .NDIG(4), .NALM(2), .ASW(1), .TMO_W(24), .TMO_CYC(8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .det_cr_i      (det_cr),
        .det_S_i       (det_S),
        .det_L_i       (det_L),
        .det_A_i       (det_A),
        .det_atSign_i  (det_at),
        .det_esc_i     (det_esc),
        .det_num_i     (det_num),
        .det_num0to5_i (det_num05),
        .num_val_i     (num_val),
        .dic_run_o     (dic_run),
        .ld_time_o     (ld_time),
        .dsp_time_o    (dsp_time),
        .ld_alm_o      (ld_alm),
        .dsp_alm_o     (dsp_alm),
        .alm_sel_o     (alm_sel),
        .alm_en_o      (alm_en),
        .entry_err_o   (entry_err)
    );

    function automatic logic [20:0] pk(input logic run, input logic [3:0] ldt, input logic [3:0] dspt,
                                       input logic [3:0] lda, input logic [3:0] dspa,
                                       input logic sel, input logic [1:0] en, input logic err);
        return {run, ldt, dspt, lda, dspa, sel, en, err};
    endfunction

    task automatic add(input int tok, input logic [3:0] val, input logic [20:0] exp);
        vec_t v;
        v.tok = tok;
        v.val = val;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input int tok, input logic [3:0] val);
        det_cr    = (tok == T_CR);
        det_S     = (tok == T_S);
        det_L     = (tok == T_L);
        det_A     = (tok == T_A);
        det_at    = (tok == T_AT);
        det_esc   = (tok == T_ESC);
        det_num   = (tok == T_NUM);
        det_num05 = (tok == T_NUM) && (val <= 4'd5);
        num_val   = val;
    endtask

    task automatic check(input string name, input logic [20:0] exp);
        logic [20:0] got;
        got = {dic_run, ld_time, dsp_time, ld_alm, dsp_alm, alm_sel, alm_en, entry_err};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%06h exp=%06h (run,ldt,dspt,lda,dspa,sel,en,err)", name, got, exp);
        end
    endtask

    // Present a token after a rising edge, sample at the falling edge, then advance.
    task automatic step(input string name, input int tok, input logic [3:0] val, input logic [20:0] exp);
        drive(tok, val);
        @(negedge clk);
        check(name, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, S / CR
        add(T_NONE, 0, pk(0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        add(T_S,    0, pk(0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        add(T_NONE, 0, pk(1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        add(T_CR,   0, pk(1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        add(T_NONE, 0, pk(0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        // L 1 2 3 4 S
        add(T_L,    0, pk(0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        add(T_NUM,  1, pk(0, 4'h8, 4'h0, 4'h0, 4'h0, 0, 2'b00, 0));
        add(T_NUM,  2, pk(0, 4'h4, 4'h8, 4'h0, 4'h0, 0, 2'b00, 0));
        add(T_NUM,  3, pk(0, 4'h2, 4'hC, 4'h0, 4'h0, 0, 2'b00, 0));
        add(T_NUM,  4, pk(0, 4'h1, 4'hE, 4'h0, 4'h0, 0, 2'b00, 0));
        add(T_S,    0, pk(0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        add(T_NONE, 0, pk(1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        // From RUN: L 7 (rejected tens) 5 ESC -> RUN
        add(T_L,    0, pk(1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        add(T_NUM,  7, pk(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2'b00, 1));
        add(T_NUM,  5, pk(0, 4'h8, 4'h0, 4'h0, 4'h0, 0, 2'b00, 0));
        add(T_ESC,  0, pk(0, 4'h0, 4'h8, 4'h0, 4'h0, 0, 2'b00, 0));
        add(T_NONE, 0, pk(1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        // A 1 0 5 0 0 @ CR @
        add(T_A,    0, pk(1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        add(T_NUM,  1, pk(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2'b00, 0));
        add(T_NUM,  0, pk(0, 4'h0, 4'h0, 4'h8, 4'h0, 1, 2'b00, 0));
        add(T_NUM,  5, pk(0, 4'h0, 4'h0, 4'h4, 4'h8, 1, 2'b00, 0));
        add(T_NUM,  0, pk(0, 4'h0, 4'h0, 4'h2, 4'hC, 1, 2'b00, 0));
        add(T_NUM,  0, pk(0, 4'h0, 4'h0, 4'h1, 4'hE, 1, 2'b00, 0));
        add(T_AT,   0, pk(0, 4'h0, 4'h0, 4'h0, 4'hF, 1, 2'b00, 0));
        add(T_CR,   0, pk(0, 4'h0, 4'h0, 4'h0, 4'hF, 1, 2'b10, 0));
        add(T_AT,   0, pk(0, 4'h0, 4'hF, 4'h0, 4'h0, 1, 2'b10, 0));
        add(T_NONE, 0, pk(0, 4'h0, 4'hF, 4'h0, 4'h0, 1, 2'b00, 0));
        // From STOP: A 3 (bad channel) 0 ESC -> STOP; stray digit ignored
        add(T_A,    0, pk(0, 4'h0, 4'hF, 4'h0, 4'h0, 1, 2'b00, 0));
        add(T_NUM,  3, pk(0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 2'b00, 1));
        add(T_NUM,  0, pk(0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 2'b00, 0));
        add(T_ESC,  0, pk(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2'b00, 0));
        add(T_NONE, 0, pk(0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        add(T_NUM,  5, pk(0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));

        rst_n = 1'b0;
        drive(T_NONE, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].tok, vecs[i].val, vecs[i].exp);
        end

        // Timeout from RUN: 8 idle cycles in LOAD -> error on the 8th, back to RUN
        step("tmo_s", T_S, 0, pk(0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        step("tmo_l", T_L, 0, pk(1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        for (int k = 0; k < 8; k++) begin
            step($sformatf("tmo_idle%0d", k), T_NONE, 0,
                 pk(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2'b00, (k == 7)));
        end
        step("tmo_back", T_NONE, 0, pk(1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));

        // Accepted digit restarts the timeout window
        step("tmo2_l", T_L, 0, pk(1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        for (int k = 0; k < 5; k++) begin
            step($sformatf("tmo2_a%0d", k), T_NONE, 0, pk(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2'b00, 0));
        end
        step("tmo2_dig", T_NUM, 1, pk(0, 4'h8, 4'h0, 4'h0, 4'h0, 0, 2'b00, 0));
        for (int k = 0; k < 8; k++) begin
            step($sformatf("tmo2_b%0d", k), T_NONE, 0,
                 pk(0, 4'h0, 4'h8, 4'h0, 4'h0, 0, 2'b00, (k == 7)));
        end
        step("tmo2_back", T_NONE, 0, pk(1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));

        // Asynchronous reset while in ALOAD with ptr=1
        step("rs_a",  T_A,   0, pk(1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        step("rs_ch", T_NUM, 1, pk(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2'b00, 0));
        step("rs_d3", T_NUM, 0, pk(0, 4'h0, 4'h0, 4'h8, 4'h0, 1, 2'b00, 0));
        step("rs_d2", T_NUM, 5, pk(0, 4'h0, 4'h0, 4'h4, 4'h8, 1, 2'b00, 0));
        step("rs_at", T_AT,  0, pk(0, 4'h0, 4'h0, 4'h0, 4'hC, 1, 2'b00, 0));
        drive(T_NUM, 3);
        @(negedge clk);
        check("rs_pre", pk(0, 4'h0, 4'h0, 4'h2, 4'hC, 1, 2'b10, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_async", pk(0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        drive(T_NONE, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("rs_s",   T_S,    0, pk(0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));
        step("rs_run", T_NONE, 0, pk(1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 2'b00, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
